snake_body: RTL

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_body_pkg.sv | 14 +
 rtl/snake_body_if.sv | 23 ++
 rtl/snake_body_seg_hit.sv | 24 ++
 rtl/snake_body.sv | 113 +++++++++++
 4 files changed

// File: rtl/snake_body_pkg.sv
// Shared constants and FSM encoding for the snake body tracker.
package snake_pkg;
  localparam int CELL     = 10;
  localparam int MAX_LEN  = 32;
  localparam int INIT_LEN = 3;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;
endpackage

// File: rtl/snake_body_if.sv
// Step/grow control, raster probe and status outputs of the snake body tracker.
interface snake_body_if;
  logic       step;
  logic [9:0] head_x;
  logic [9:0] head_y;
  logic       grow;
  logic       pause;
  logic [9:0] pixel_row;
  logic [9:0] pixel_column;
  logic       body_on;
  logic       self_hit;
  logic [5:0] length;

  modport master (
    output step, head_x, head_y, grow, pause, pixel_row, pixel_column,
    input  body_on, self_hit, length
  );

  modport slave (
    input  step, head_x, head_y, grow, pause, pixel_row, pixel_column,
    output body_on, self_hit, length
  );
endinterface

// File: rtl/snake_body_seg_hit.sv
// One history entry: exact match against the head, and raster pixel inside its cell.
module seg_hit #(
  parameter int CELL = 10
) (
  input  logic [9:0] ent_x,
  input  logic [9:0] ent_y,
  input  logic [9:0] head_x,
  input  logic [9:0] head_y,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       pt_eq,
  output logic       in_box
);
  logic [10:0] x_hi;
  logic [10:0] y_hi;

  // Upper box edges carried in 11 bits so cells near 1023 do not wrap.
  assign x_hi = {1'b0, ent_x} + 11'(CELL - 1);
  assign y_hi = {1'b0, ent_y} + 11'(CELL - 1);

  assign pt_eq  = (head_x == ent_x) && (head_y == ent_y);
  assign in_box = (pix_x >= ent_x) && ({1'b0, pix_x} <= x_hi) &&
                  (pix_y >= ent_y) && ({1'b0, pix_y} <= y_hi);
endmodule

// File: rtl/snake_body.sv
// Snake body history: circular head buffer, tail drop by length, self-collision, raster overlay.
// state | meaning: IDLE no step yet | RUN tracking | DEAD collided, frozen until reset
module snake_body #(
  parameter int MAX_LEN  = snake_pkg::MAX_LEN,
  parameter int INIT_LEN = snake_pkg::INIT_LEN,
  parameter int CELL     = snake_pkg::CELL
) (
  input logic         clk,
  input logic         reset,
  snake_body_if.slave bus
);
  import snake_pkg::*;

  localparam int         PTR_W      = $clog2(MAX_LEN);
  localparam logic [5:0] MAX_LEN_L  = 6'(MAX_LEN);
  localparam logic [5:0] INIT_LEN_L = 6'(INIT_LEN);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [5:0]         filled_q, filled_d;
  logic [5:0]         length_q, length_d;
  logic               grow_pending_q, grow_pending_d;
  logic               self_hit_q, self_hit_d;
  logic               body_on_q, body_on_d;
  logic [19:0]        mem_q [MAX_LEN];
  logic [19:0]        mem_d [MAX_LEN];
  logic [MAX_LEN-1:0] live, pt_eq, in_box;
  logic               can_update, step_acc, hit, grow_now;
  logic [5:0]         filled_inc;

  for (genvar i = 0; i < MAX_LEN; i++) begin : gen_seg
    logic [PTR_W-1:0] age;
    assign age     = wr_ptr_q - PTR_W'(1) - PTR_W'(i);
    assign live[i] = 6'(age) < filled_q;

    seg_hit #(.CELL(CELL)) u_seg_hit (
      .ent_x  (mem_q[i][19:10]),
      .ent_y  (mem_q[i][9:0]),
      .head_x (bus.head_x),
      .head_y (bus.head_y),
      .pix_x  (bus.pixel_column),
      .pix_y  (bus.pixel_row),
      .pt_eq  (pt_eq[i]),
      .in_box (in_box[i])
    );
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    filled_d       = filled_q;
    length_d       = length_q;
    grow_pending_d = grow_pending_q;
    self_hit_d     = self_hit_q;
    mem_d          = mem_q;
    filled_inc     = filled_q + 6'd1;

    can_update = !bus.pause && (state_q != DEAD);
    step_acc   = can_update && bus.step;
    hit        = |(pt_eq & live);
    grow_now   = grow_pending_q || (can_update && bus.grow);

    if (can_update && bus.grow) grow_pending_d = 1'b1;

    if (step_acc) begin
      if (hit) begin
        self_hit_d = 1'b1;
        state_d    = DEAD;
      end else begin
        mem_d[wr_ptr_q] = {bus.head_x, bus.head_y};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        state_d         = RUN;
        if (grow_now) begin
          grow_pending_d = 1'b0;
          if (length_q < MAX_LEN_L) length_d = length_q + 6'd1;
        end
        // Fill is capped by the post-growth length so a growing step keeps the old tail.
        filled_d = (filled_inc > length_d) ? length_d : filled_inc;
      end
    end

    body_on_d = (state_q != IDLE) && |(in_box & live);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      filled_q       <= '0;
      length_q       <= INIT_LEN_L;
      grow_pending_q <= 1'b0;
      self_hit_q     <= 1'b0;
      body_on_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      filled_q       <= filled_d;
      length_q       <= length_d;
      grow_pending_q <= grow_pending_d;
      self_hit_q     <= self_hit_d;
      body_on_q      <= body_on_d;
    end
  end

  // Entries outside the live window are masked, so the storage needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.body_on  = body_on_q;
  assign bus.self_hit = self_hit_q;
  assign bus.length   = length_q;
endmodule
